// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the memory-op AluOp codes, a few representative pass-through codes,
// the LSU FSM state encoding, ZeroWord, and small op-decoding helpers.
package mem_lsu_pkg;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Pass-through examples; any code not listed among the memory ops
    // below is forwarded untouched.
    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_SUB = 8'h02;
    localparam logic [7:0] ALU_OR  = 8'h03;

    localparam logic [7:0] LD_B  = 8'h80;
    localparam logic [7:0] LD_H  = 8'h81;
    localparam logic [7:0] LD_W  = 8'h82;
    localparam logic [7:0] LD_BU = 8'h83;
    localparam logic [7:0] LD_HU = 8'h84;
    localparam logic [7:0] ST_B  = 8'h88;
    localparam logic [7:0] ST_H  = 8'h89;
    localparam logic [7:0] ST_W  = 8'h8A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            LD_B, LD_H, LD_W, LD_BU, LD_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            ST_B, ST_H, ST_W: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load(op) | is_store(op);
    endfunction

    // Halfwords need an even address, words a 4-byte boundary.
    function automatic logic is_aligned(input logic [7:0] op, input logic [1:0] a);
        case (op)
            LD_H, LD_HU, ST_H: return ~a[0];
            LD_W, ST_W:        return (a == 2'b00);
            default:           return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// load_align: combinational load-data extraction.
// Picks the addressed byte/halfword out of the bus word and sign- or
// zero-extends it according to the load op.
//   op    - latched AluOp of the load
//   addr  - low two address bits of the access
//   rdata - raw 32-bit bus word
//   value - register-file ready result (ZeroWord for non-load ops)
module load_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            LD_B:    value = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   value = {24'h000000, byte_sel};
            LD_H:    value = {{16{half_sel[15]}}, half_sel};
            LD_HU:   value = {16'h0000, half_sel};
            LD_W:    value = rdata;
            default: value = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Pass-through ops are registered to the writeback outputs with one cycle of
// latency. Aligned loads/stores run a single-beat bus transaction
// (IDLE -> REQ -> RESP); misaligned ones are dropped with an ale_o pulse.
//   clk, rst                 - clock, synchronous active-high reset
//   valid_i, aluop_i, mem_addr_i, store_data_i, wd_i, wreg_i, wdata_i
//                            - EX-stage result (held while stall_o=1)
//   req_o, we_o, addr_o, wstrb_o, bus_wdata_o - data-bus request
//   ack_i, rdata_i           - data-bus response
//   valid_o, wd_o, wreg_o, wdata_o, ale_o     - registered writeback result
//   stall_o                  - upstream hold
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        ale_o,
    output logic        stall_o
);

    lsu_state_t  state_reg, state_next;
    logic [7:0]  op_reg;
    logic [31:0] addr_reg;
    logic [31:0] sdata_reg;
    logic [4:0]  wd_reg;
    logic        wreg_reg;

    logic        valid_o_reg, wreg_o_reg, ale_o_reg;
    logic [4:0]  wd_o_reg;
    logic [31:0] wdata_o_reg;

    logic        in_mem_op, in_aligned, accept_mem, in_req;
    logic [3:0]  strb_next;
    logic [31:0] wdata_repl;
    logic [31:0] load_value;

    assign in_mem_op  = is_mem_op(aluop_i);
    assign in_aligned = is_aligned(aluop_i, mem_addr_i[1:0]);
    assign accept_mem = (state_reg == IDLE) && valid_i && in_mem_op && in_aligned;
    assign in_req     = (state_reg == REQ);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_mem) state_next = REQ;
            REQ:     if (ack_i)      state_next = RESP;
            RESP:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Byte lane gi carries store byte (gi mod access size), so any lane the
    // strobe selects already holds the right data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_repl[8*gi +: 8] =
                (op_reg == ST_B) ? sdata_reg[7:0] :
                (op_reg == ST_H) ? sdata_reg[8*(gi%2) +: 8] :
                                   sdata_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (op_reg)
            ST_B:    strb_next = 4'b0001 << addr_reg[1:0];
            ST_H:    strb_next = 4'b0011 << addr_reg[1:0];
            ST_W:    strb_next = 4'b1111;
            default: strb_next = 4'b0000;
        endcase
    end

    // Bus outputs are derived from the latched op, so they stay constant for
    // the whole REQ phase and read as zero outside it.
    assign req_o       = in_req;
    assign we_o        = in_req & is_store(op_reg);
    assign addr_o      = in_req ? {addr_reg[31:2], 2'b00} : ZeroWord;
    assign wstrb_o     = in_req ? strb_next : 4'b0000;
    assign bus_wdata_o = (in_req && is_store(op_reg)) ? wdata_repl : ZeroWord;

    // The accept term is combinational so the op is held through the accept
    // edge; reset overrides it.
    assign stall_o = ~rst & (accept_mem | in_req);

    load_align u_load_align (
        .op    (op_reg),
        .addr  (addr_reg[1:0]),
        .rdata (rdata_i),
        .value (load_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            op_reg      <= ALU_NOP;
            addr_reg    <= ZeroWord;
            sdata_reg   <= ZeroWord;
            wd_reg      <= 5'd0;
            wreg_reg    <= 1'b0;
            valid_o_reg <= 1'b0;
            wd_o_reg    <= 5'd0;
            wreg_o_reg  <= 1'b0;
            wdata_o_reg <= ZeroWord;
            ale_o_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            valid_o_reg <= 1'b0;
            ale_o_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        if (!in_mem_op) begin
                            valid_o_reg <= 1'b1;
                            wd_o_reg    <= wd_i;
                            wreg_o_reg  <= wreg_i;
                            wdata_o_reg <= wdata_i;
                        end else if (!in_aligned) begin
                            valid_o_reg <= 1'b1;
                            ale_o_reg   <= 1'b1;
                            wd_o_reg    <= wd_i;
                            wreg_o_reg  <= 1'b0;
                            wdata_o_reg <= ZeroWord;
                        end else begin
                            op_reg    <= aluop_i;
                            addr_reg  <= mem_addr_i;
                            sdata_reg <= store_data_i;
                            wd_reg    <= wd_i;
                            wreg_reg  <= wreg_i;
                        end
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        valid_o_reg <= 1'b1;
                        wd_o_reg    <= wd_reg;
                        wreg_o_reg  <= is_load(op_reg) & wreg_reg;
                        wdata_o_reg <= is_load(op_reg) ? load_value : ZeroWord;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o = valid_o_reg;
    assign wd_o    = wd_o_reg;
    assign wreg_o  = wreg_o_reg;
    assign wdata_o = wdata_o_reg;
    assign ale_o   = ale_o_reg;

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL expose: clk input 1 -- rising-edge clock; all state updates on this edge.
REQ-002 SHALL expose: rst input 1 -- reset, synchronous, active-high.
REQ-003 SHALL expose: valid_i input 1 -- EX-stage result valid this cycle.
REQ-004 SHALL expose: aluop_i input 8 -- operation code, shared AluOp encoding.
REQ-005 SHALL expose: mem_addr_i input 32 -- effective address (base + sign-extended 12-bit offset).
REQ-006 SHALL expose: store_data_i input 32 -- store source register value.
REQ-007 SHALL expose: wd_i input 5, wreg_i input 1, wdata_i input 32 -- writeback destination, enable, EX result.
REQ-008 SHALL expose: req_o output 1, we_o output 1, addr_o output 32, wstrb_o output 4, bus_wdata_o output 32 -- data-bus request.
REQ-009 SHALL expose: ack_i input 1, rdata_i input 32 -- data-bus response; rdata_i valid only when ack_i=1.
REQ-010 SHALL expose: valid_o output 1, wd_o output 5, wreg_o output 1, wdata_o output 32 -- registered writeback result.
REQ-011 SHALL expose: ale_o output 1 -- address-misalignment pulse, coincident with valid_o.
REQ-012 SHALL expose: stall_o output 1 -- upstream hold; EX inputs SHALL stay stable while stall_o=1.

Function
REQ-013 Memory ops SHALL be LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W; every other aluop_i is a pass-through op.
REQ-014 FSM states SHALL be IDLE, REQ, RESP.
REQ-015 IDLE: valid_i with pass-through op SHALL register wd_i/wreg_i/wdata_i and pulse valid_o next cycle (latency 1), no bus activity.
REQ-016 IDLE: valid_i with aligned memory op SHALL latch op, address, data, wd_i, and go to REQ.
REQ-017 Alignment SHALL be: H requires addr[0]=0; W requires addr[1:0]=0; B always aligned.
REQ-018 IDLE: valid_i with misaligned memory op SHALL issue no request and next cycle pulse valid_o=1, ale_o=1, wreg_o=0.
REQ-019 REQ: req_o=1, addr_o={latched addr[31:2],2'b00}; we_o=1 for stores, 0 for loads; held stable until ack_i=1 sampled.
REQ-020 Store strobes SHALL be: ST_B 4'b0001<<addr[1:0]; ST_H 4'b0011<<addr[1:0]; ST_W 4'b1111; loads 4'b0000.
REQ-021 bus_wdata_o SHALL replicate store data: B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
REQ-022 REQ with ack_i=1 SHALL register response and go to RESP; req_o SHALL drop in the following cycle.
REQ-023 Load extraction: select byte/half by addr[1:0]/addr[1]; LD_B/LD_H sign-extend, LD_BU/LD_HU zero-extend, LD_W full word.
REQ-024 RESP SHALL pulse valid_o=1 for exactly one cycle, then go to IDLE; loads wreg_o=latched wreg, stores wreg_o=0.
REQ-025 stall_o SHALL be 1 in IDLE when accepting an aligned memory op, and in REQ; it SHALL be 0 in RESP and otherwise.
REQ-026 valid_o SHALL be 0 in every cycle not specified above; ack_i outside REQ SHALL be ignored.
REQ-027 Minimum memory-op latency SHALL be 3 cycles (accept, REQ with ack, RESP); each extra wait cycle adds one.

Reset
REQ-028 rst=1 SHALL force state IDLE and req_o, we_o, wstrb_o, valid_o, wreg_o, ale_o, stall_o to 0; addr_o, bus_wdata_o, wdata_o, wd_o to 0.
REQ-029 rst asserted in REQ SHALL abandon the transaction; req_o=0 from the next edge, and any later ack_i SHALL be ignored.

Structure
REQ-030 LD_*/ST_* aluop codes, state encoding, and ZeroWord SHALL live in the shared defines package.
REQ-031 Load extraction/extension SHALL be a combinational sub-module load_align (inputs op, addr[1:0], rdata; output 32-bit value).

Verification
REQ-032 LD_B addr=0x1003, rdata_i=0x80FF_FF7F, ack next cycle -> wdata_o=0xFFFF_FF80, wreg_o=1, valid_o one cycle, total 3 cycles.
REQ-033 ST_H addr=0x2002, data=0x1234_ABCD -> addr_o=0x2000, wstrb_o=4'b1100, bus_wdata_o=0xABCD_ABCD, we_o=1, valid_o with wreg_o=0.
REQ-034 LD_W addr=0x3000, ack_i delayed 4 cycles -> req_o/addr_o stable for 4 cycles, stall_o high throughout, valid_o 1 cycle after ack.
REQ-035 LD_W addr=0x3002 -> no req_o, next cycle valid_o=1, ale_o=1, wreg_o=0.
REQ-036 Pass-through ADD result 0x5, wd_i=4 -> next cycle valid_o=1, wdata_o=0x5, wd_o=4, stall_o never high.
REQ-037 rst pulsed during REQ, then ack_i=1 -> state IDLE, req_o=0, no valid_o.
